// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: access size codes, FSM states,
// lane count and the alignment check used when misaligned accesses trap.
package mau_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP,
    RESP_ERR
  } state_e;

  function automatic logic misaligned(input size_e size, input logic [1:0] lo);
    case (size)
      SIZE_HALF: misaligned = lo[0];
      SIZE_WORD: misaligned = |lo;
      default:   misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane_unit.sv
// Combinational byte-lane logic: merges store data into a read word and
// extracts/extends load data from a RAM word.
module mau_lane_unit
  import mau_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] extracted
);

  function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic u);
    logic signed [7:0]  sb;
    logic signed [31:0] sx;
    sb = b;
    sx = sb;
    extend_byte = u ? {24'd0, b} : sx;
  endfunction

  function automatic logic [31:0] extend_half(input logic [15:0] h, input logic u);
    logic signed [15:0] sh;
    logic signed [31:0] sx;
    sh = h;
    sx = sh;
    extend_half = u ? {16'd0, h} : sx;
  endfunction

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = word[{lane, 3'b000} +: 8];
  assign lane_half = word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    merged    = word;
    extracted = word;
    case (size)
      SIZE_BYTE: begin
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
        extracted = extend_byte(lane_byte, is_unsigned);
      end
      SIZE_HALF: begin
        merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        extracted = extend_half(lane_half, is_unsigned);
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end for a word-wide data RAM with read-modify-write sub-word stores.
// Define MAU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors instead of aligning down.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  state_e state, state_next;

  logic                  accept;
  logic                  req_err;
  size_e                 req_size;
  logic [ADDR_WIDTH-1:0] addr_eff;

  logic                  we_p1;
  logic                  unsigned_p1;
  size_e                 size_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [DATA_WIDTH-1:0] wdata_p1;
  logic [DATA_WIDTH-1:0] merge_p2;
  logic [DATA_WIDTH-1:0] rdata_p2;

  logic [DATA_WIDTH-1:0] lane_word;
  logic [DATA_WIDTH-1:0] lane_merged;
  logic [DATA_WIDTH-1:0] lane_extracted;

  assign accept   = req_valid_i && req_ready_o;
  assign req_size = size_e'(req_size_i);

`ifdef MAU_MISALIGN_TRAP_EN
  assign req_err  = (req_size == SIZE_RSVD) || misaligned(req_size, req_addr_i[1:0]);
  assign addr_eff = req_addr_i;
`else
  assign req_err  = (req_size == SIZE_RSVD);
  always_comb begin
    addr_eff = req_addr_i;
    case (req_size)
      SIZE_HALF: addr_eff[0]   = 1'b0;
      SIZE_WORD: addr_eff[1:0] = 2'b00;
      default:   ;
    endcase
  end
`endif

  // Stage p1: request fields captured at accept
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_p1       <= req_we_i;
      unsigned_p1 <= req_unsigned_i;
      size_p1     <= req_size;
      addr_p1     <= addr_eff;
      wdata_p1    <= req_wdata_i;
    end
  end

  // Stage p2: RAM word captured during ACCESS (merge source or load result)
  always_ff @(posedge clk_i) begin
    if (state == ACCESS) begin
      merge_p2 <= ram_rdata_i;
      rdata_p2 <= we_p1 ? '0 : lane_extracted;
    end
  end

  assign lane_word = (state == WRITE) ? merge_p2 : ram_rdata_i;

  mau_lane_unit u_lane (
    .size        (size_p1),
    .lane        (addr_p1[1:0]),
    .is_unsigned (unsigned_p1),
    .word        (lane_word),
    .wdata       (wdata_p1),
    .merged      (lane_merged),
    .extracted   (lane_extracted)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept) state_next = req_err ? RESP_ERR : ACCESS;
      ACCESS:   state_next = (we_p1 && size_p1 != SIZE_WORD) ? WRITE : RESP;
      WRITE:    state_next = RESP;
      RESP:     state_next = IDLE;
      RESP_ERR: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Write enable is forced low during reset so an aborted access never reaches the RAM.
  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_err_o   = 1'b0;
    rsp_rdata_o = '0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    case (state)
      IDLE: req_ready_o = 1'b1;
      ACCESS: begin
        ram_addr_o = {addr_p1[ADDR_WIDTH-1:2], 2'b00};
        if (we_p1 && size_p1 == SIZE_WORD) begin
          ram_we_o    = !rst_i;
          ram_wdata_o = wdata_p1;
        end
      end
      WRITE: begin
        ram_addr_o  = {addr_p1[ADDR_WIDTH-1:2], 2'b00};
        ram_we_o    = !rst_i;
        ram_wdata_o = lane_merged;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = rdata_p2;
      end
      RESP_ERR: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-level reference memory model,
// directed requests with latency/data/write checks and a per-cycle monitor.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;

  bit [31:0] tb_mem   [64];
  bit [31:0] ref_words[64];
  int checks = 0;
  int failures = 0;
  bit busy = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .ram_we_o       (ram_we_o),
    .ram_addr_o     (ram_addr_o),
    .ram_wdata_o    (ram_wdata_o),
    .ram_rdata_i    (ram_rdata_i)
  );

  assign ram_rdata_i = tb_mem[ram_addr_o[7:2]];
  always @(posedge clk) if (ram_we_o) tb_mem[ram_addr_o[7:2]] <= ram_wdata_o;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: little-endian byte memory; computes response, latency and written word.
  function automatic void model(input bit we, input bit [1:0] sz, input bit uns,
                                input bit [31:0] a, input bit [31:0] wd,
                                output bit err, output bit [31:0] rd, output int lat,
                                output int wk, output bit [31:0] ww, output bit [31:0] ea);
    int n;
    longint v;
    bit [31:0] b;
    err = 1'b0; rd = '0; wk = 0; ww = '0; lat = 1; ea = a;
    if (sz == 2'b11) begin err = 1'b1; return; end
    n = 1 << sz;
`ifdef MAU_MISALIGN_TRAP_EN
    if (a % n != 0) begin err = 1'b1; return; end
`endif
    ea = a - (a % n);
    if (!we) begin
      v = 0;
      for (int i = 0; i < n; i++) begin
        b = ea + i;
        v = v | (longint'(ref_words[b[7:2]][int'(b[1:0])*8 +: 8]) << (8*i));
      end
      if (!uns && n < 4 && v >= (longint'(1) << (8*n-1))) v = v - (longint'(1) << (8*n));
      rd = v[31:0];
      lat = 2;
    end else begin
      for (int i = 0; i < n; i++) begin
        b = ea + i;
        ref_words[b[7:2]][int'(b[1:0])*8 +: 8] = wd[8*i +: 8];
      end
      ww = ref_words[ea[7:2]];
      lat = (n == 4) ? 2 : 3;
      wk = lat - 1;
    end
  endfunction

  task automatic drive(input bit we, input bit [1:0] sz, input bit uns,
                       input bit [31:0] a, input bit [31:0] wd, output bit ok);
    int n = 0;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = sz;
    req_unsigned_i = uns; req_addr_i = a; req_wdata_i = wd;
    while (!req_ready_o && n < 10) begin @(negedge clk); n++; end
    ok = req_ready_o;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=%0d required=0", n);
    end
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic run(input string nm, input bit we, input bit [1:0] sz, input bit uns,
                     input bit [31:0] a, input bit [31:0] wd,
                     input bit has_lit, input bit lit_err, input bit [31:0] lit);
    bit e, ok; bit [31:0] rd, ww, ea; int lat, wk, seen, wseen;
    model(we, sz, uns, a, wd, e, rd, lat, wk, ww, ea);
    if (has_lit) begin
      chk({nm, "_model_err"}, {31'd0, e}, {31'd0, lit_err});
      if (!lit_err) chk({nm, "_model_val"}, we ? ww : rd, lit);
    end
    busy = 1'b1;
    drive(we, sz, uns, a, wd, ok);
    if (!ok) begin busy = 1'b0; return; end
    seen = 0; wseen = 0;
    for (int k = 1; k <= 6 && seen == 0; k++) begin
      if (k > 1) @(negedge clk);
      if (ram_we_o) begin
        wseen = (wseen == 0) ? k : 99;
        chk({nm, "_ram_wdata"}, ram_wdata_o, ww);
        chk({nm, "_ram_addr"}, ram_addr_o, {ea[31:2], 2'b00});
      end
      if (rsp_valid_o) seen = k;
      else chk({nm, "_ready_busy"}, {31'd0, req_ready_o}, 32'd0);
    end
    chk({nm, "_latency"}, seen, lat);
    chk({nm, "_write_cycle"}, wseen, wk);
    if (seen != 0) begin
      chk({nm, "_err"}, {31'd0, rsp_err_o}, {31'd0, e});
      chk({nm, "_rdata"}, rsp_rdata_o, rd);
    end
    @(negedge clk);
    chk({nm, "_ready_after"}, {31'd0, req_ready_o}, 32'd1);
    chk({nm, "_single_pulse"}, {31'd0, rsp_valid_o}, 32'd0);
    busy = 1'b0;
  endtask

  // Reset asserted while the request sits in ACCESS; the write must never happen.
  task automatic reset_abort(input string nm, input bit [1:0] sz, input bit [31:0] a, input bit [31:0] wd);
    bit ok;
    drive(1'b1, sz, 1'b0, a, wd, ok);
    if (!ok) return;
    rst_i = 1'b1;
    #1 chk({nm, "_we_gated"}, {31'd0, ram_we_o}, 32'd0);
    @(negedge clk);
    chk({nm, "_we_in_reset"}, {31'd0, ram_we_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk);
    chk({nm, "_ready"}, {31'd0, req_ready_o}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk({nm, "_no_rsp"}, {31'd0, rsp_valid_o}, 32'd0);
      chk({nm, "_no_we"}, {31'd0, ram_we_o}, 32'd0);
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    if (rst_i) chk("mon_we_in_reset", {31'd0, ram_we_o}, 32'd0);
    if (rsp_valid_o) chk("mon_unexpected_rsp", {31'd0, busy}, 32'd1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_ready", {31'd0, req_ready_o}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err_o}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata_o, 32'd0);
    chk("reset_ram_addr", ram_addr_o, 32'd0);
    chk("reset_ram_wdata", ram_wdata_o, 32'd0);
    rst_i = 1'b0;

    run("st_word_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF);
    run("ld_word_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
    run("st_word_20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 1'b0, 1'b0, 32'h0);
    run("st_byte_21", 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, 1'b1, 1'b0, 32'h1122AA44);
    run("ld_word_20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h1122AA44);
    run("st_word_30", 1'b1, 2'b10, 1'b0, 32'h30, 32'h80FF7F01, 1'b0, 1'b0, 32'h0);
    run("ld_sbyte_33", 1'b0, 2'b00, 1'b0, 32'h33, 32'h0, 1'b1, 1'b0, 32'hFFFFFF80);
    run("ld_ubyte_33", 1'b0, 2'b00, 1'b1, 32'h33, 32'h0, 1'b1, 1'b0, 32'h00000080);
    run("ld_shalf_30", 1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0, 32'h00007F01);
    run("ld_shalf_32", 1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 1'b1, 1'b0, 32'hFFFF80FF);
    run("ld_uhalf_32", 1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 1'b1, 1'b0, 32'h000080FF);
    run("ld_sbyte_31", 1'b0, 2'b00, 1'b0, 32'h31, 32'h0, 1'b1, 1'b0, 32'h0000007F);
    run("st_half_32", 1'b1, 2'b01, 1'b0, 32'h32, 32'hFFFF1234, 1'b1, 1'b0, 32'h12347F01);
    run("st_byte_30", 1'b1, 2'b00, 1'b0, 32'h30, 32'h123456C3, 1'b1, 1'b0, 32'h12347FC3);
    run("st_word_40", 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0);
`ifdef MAU_MISALIGN_TRAP_EN
    run("ld_word_42", 1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 1'b1, 1'b1, 32'h0);
`else
    run("ld_word_42", 1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D);
`endif
    run("st_half_23", 1'b1, 2'b01, 1'b0, 32'h23, 32'h0000BEEF, 1'b0, 1'b0, 32'h0);
    run("st_word_13", 1'b1, 2'b10, 1'b0, 32'h13, 32'h01020304, 1'b0, 1'b0, 32'h0);
    run("st_rsvd_20", 1'b1, 2'b11, 1'b0, 32'h20, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0);
    run("ld_rsvd_10", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h0);
    run("ld_word_wrap", 1'b0, 2'b10, 1'b0, 32'hFFFFFF20, 32'h0, 1'b0, 1'b0, 32'h0);

    reset_abort("rst_byte_21", 2'b00, 32'h21, 32'h00000055);
    reset_abort("rst_word_50", 2'b10, 32'h50, 32'h55555555);
    run("ld_word_20_after_rst", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 64; i++) chk($sformatf("ram_image_%0d", i), tb_mem[i], ref_words[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front-end placed directly upstream of the word-wide data RAM.
- Accepts byte/halfword/word loads and stores from the pipeline MEM stage through a valid/ready handshake.
- Converts each request into RAM word accesses:
  - sub-word stores use read-modify-write;
  - loads are lane-extracted and sign- or zero-extended.
- Returns one response pulse per accepted request.

Parameters:
- ADDR_WIDTH, 32, byte-address width; equals the RAM address width.
- DATA_WIDTH, 32, data width; fixed to 32 (4 byte lanes).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  unit can accept; high only in IDLE.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned_i  in  1  load zero-extends when 1.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_wdata_i  in  DATA_WIDTH  store data, LSB-justified.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_rdata_o  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  misaligned or reserved-size request; no RAM write occurred.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  ADDR_WIDTH  word-aligned address: {addr[ADDR_WIDTH-1:2], 2'b00}.
- ram_wdata_o  out  DATA_WIDTH  full word to write.
- ram_rdata_i  in  DATA_WIDTH  combinational RAM read data for ram_addr_o.

Behaviour:
- Reset values (synchronous, rst_i high):
  - state = IDLE;
  - rsp_valid_o = 0, rsp_err_o = 0, rsp_rdata_o = 0;
  - ram_we_o = 0, ram_addr_o = 0, ram_wdata_o = 0.
  - ram_we_o is also combinationally gated low while rst_i = 1.
- Handshake:
  - Accept occurs when req_valid_i && req_ready_o.
  - All request fields are latched at accept.
  - Only one request is in flight at a time.
  - The response has no backpressure.
- State IDLE:
  - req_ready_o = 1.
  - On accept with an error condition -> RESP_ERR.
  - On accept otherwise -> ACCESS.
- Error condition:
  - size = 11; or
  - half with addr[0] = 1; or
  - word with addr[1:0] != 0.
- State ACCESS:
  - ram_addr_o is driven from the latched address.
  - Load: extract lane and extend; register the result into rsp_rdata_o. Next state RESP.
  - Word store: ram_we_o = 1, ram_wdata_o = wdata. Next state RESP.
  - Sub-word store: capture ram_rdata_i into a merge register. Next state WRITE.
- State WRITE:
  - ram_we_o = 1.
  - ram_wdata_o = captured word with the target lanes replaced:
    - byte: lane addr[1:0] replaced by wdata[7:0];
    - half: lanes {addr[1],0}+1 and {addr[1],0} replaced by wdata[15:0].
  - Next state RESP.
- States RESP and RESP_ERR:
  - rsp_valid_o = 1 for one cycle.
  - rsp_err_o = 1 in RESP_ERR only.
  - Next state IDLE.
- Load extraction:
  - byte: lane addr[1:0];
  - half: lanes selected by addr[1];
  - sign-extend from bit 7 or bit 15 unless req_unsigned_i = 1.
- Latency from the accept cycle T:
  - load and word store: rsp_valid_o at T+2;
  - sub-word store: rsp_valid_o at T+3;
  - error: rsp_valid_o at T+1.
- Throughput: the next accept is possible in the same cycle as rsp_valid_o? No. req_ready_o returns high the cycle after RESP.
- Boundaries:
  - Reset in WRITE or ACCESS aborts the operation: no write, no response.
  - Address wrap-around is not special-cased; upper address bits pass through.
  - req_valid_i deasserting while not ready is legal and ignored.

Optional Feature:
- Macro MAU_MISALIGN_TRAP_EN.
- Defined: misaligned half/word accesses flag rsp_err_o as described above.
- Undefined: misaligned accesses are silently aligned down (half clears bit 0, word clears bits 1:0) and processed normally with no error.
- Reserved size 11 always errors, whether or not the macro is defined.

Decomposition:
- Package mau_pkg holds:
  - size encodings SIZE_BYTE / SIZE_HALF / SIZE_WORD / SIZE_RSVD;
  - the FSM state enum (IDLE, ACCESS, WRITE, RESP, RESP_ERR);
  - the lane count constant.
- One sub-module, mau_lane_unit: purely combinational lane merge (store) and lane extract/extend (load), instantiated once.

Test Plan:
- Word store addr 0x10, data 0xDEADBEEF, then word load 0x10 -> ram_we_o pulses once at T+1; load rsp_rdata_o = 0xDEADBEEF at T+2.
- RAM word 0x11223344 at 0x20; byte store 0xAA to 0x21 -> read at T+1, write 0x1122AA44 at T+2, rsp at T+3.
- RAM word 0x80FF7F01 at 0x30:
  - signed byte load 0x33 -> 0xFFFFFF80;
  - unsigned -> 0x00000080;
  - signed half load 0x30 -> 0x00007F01.
- With macro defined: word load at 0x42 -> rsp_err_o = 1 at T+1, no ram_we_o. Without macro: same request reads word 0x40.
- Reset asserted during WRITE of a byte store -> ram_we_o never asserted, no rsp_valid_o, req_ready_o = 1 the cycle after reset.
- req_size_i = 11 store -> rsp_err_o = 1, RAM unchanged, in both macro builds.
